vsq_vector_loader: RTL

Read-side counterpart of the PPU quantize path. The block fetches per-vector-quantized vectors from activation/weight SRAM, where each 136-bit word holds 16 unsigned 8-bit lanes plus an 8-bit per-vector scale. It streams them to the MAC array over a valid/ready interface, tagging each vector with the per-tensor fp8 gamma latched at start. A 2-entry output FIFO with credit-based read issue gives full throughput under no backpressure and no data loss under backpressure.

---
 rtl/vsq_vector_loader_if.sv | 47 ++++
 rtl/vsq_vector_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vsq_vector_loader_if.sv
// Bus bundle for vsq_vector_loader.
// Carries the SRAM read port and the valid/ready vector stream to the MAC array.
//   master : loader side (drives SRAM request and output stream)
//   slave  : environment side (SRAM data return and stream consumer)
// Signals:
//   sram_en / sram_addr   read request, one word per asserted cycle
//   sram_rdata            read data, valid one cycle after sram_en
//   out_valid / out_ready stream handshake
//   out_data / out_vscale 16 x 8-bit lanes and per-vector scale
//   out_gamma / out_last  per-tensor fp8 scale and end-of-transfer marker
interface vsq_vector_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [135:0]      sram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_data;
    logic [7:0]        out_vscale;
    logic [7:0]        out_gamma;
    logic              out_last;

    modport master (
        output sram_en,
        output sram_addr,
        input  sram_rdata,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_vscale,
        output out_gamma,
        output out_last
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_rdata,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_vscale,
        input  out_gamma,
        input  out_last
    );
endinterface

// File: rtl/vsq_vector_loader.sv
// Per-vector-quantized vector loader.
// Reads num_vec consecutive 136-bit SRAM words (16 x u8 lanes + u8 scale) starting at
// base_addr and streams them over valid/ready, tagged with the fp8 gamma latched at start.
// A 2-entry output FIFO plus credit-gated read issue keeps full rate without backpressure
// and never drops a returning word under backpressure.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request, honoured only when idle
//   base_addr/num_vec first word address and vector count, sampled with start
//   gamma             per-tensor fp8 scale, latched with start
//   bus               SRAM read port and output stream (master modport)
//   busy              high while a transfer is active
//   done_wire         one-cycle pulse at transfer end
module vsq_vector_loader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W-1:0]          num_vec,
    input  logic [7:0]                 gamma,
    vsq_vector_loader_if.master        bus,
    output logic                       busy,
    output logic                       done_wire
);

    localparam int unsigned CntW = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, num_q;
    logic [7:0]        gamma_q;
    logic [CntW-1:0]   issued_q, accepted_q;
    logic              inflight_q, inflight_last_q;
    logic              zero_done_q;

    // FIFO: head entry drives the outputs, tail holds the second word.
    logic [1:0]        occ_q, occ_d;
    logic [135:0]      head_q, head_d, tail_q, tail_d;
    logic              head_last_q, head_last_d, tail_last_q, tail_last_d;

    logic              start_ok, pop, push, out_valid_int, sram_en_int;
    logic              issue_more, credit_ok, issue_last, drain_done;
    logic [CntW-1:0]   num_ext;
    logic [31:0]       used_slots, slot_limit;

    assign num_ext       = {1'b0, num_q};
    assign start_ok      = (state_q == StIdle) && start;
    assign out_valid_int = (occ_q != 2'd0);
    assign pop           = out_valid_int && bus.out_ready;
    assign push          = inflight_q;

    // A read may issue only if its word is guaranteed a slot when it returns:
    // occ + inflight - pop < depth, rearranged to stay non-negative.
    assign used_slots  = 32'(occ_q) + 32'(inflight_q);
    assign slot_limit  = FIFO_DEPTH + 32'(pop);
    assign credit_ok   = used_slots < slot_limit;
    assign issue_more  = issued_q < num_ext;
    assign issue_last  = (issued_q + CntW'(1)) == num_ext;
    assign sram_en_int = (state_q == StRun) && issue_more && credit_ok;

    assign drain_done = (state_q == StDrain) && (occ_q == 2'd0) && !inflight_q &&
                        (accepted_q == num_ext);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && (num_vec != '0)) state_d = StRun;
            StRun:   if (sram_en_int && issue_last) state_d = StDrain;
            StDrain: if (drain_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        head_last_d = head_last_q;
        tail_last_d = tail_last_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d      = bus.sram_rdata;
                    head_last_d = inflight_last_q;
                end else begin
                    tail_d      = bus.sram_rdata;
                    tail_last_d = inflight_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d      = tail_q;
                head_last_d = tail_last_q;
                occ_d       = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d      = bus.sram_rdata;
                    head_last_d = inflight_last_q;
                end else begin
                    head_d      = tail_q;
                    head_last_d = tail_last_q;
                    tail_d      = bus.sram_rdata;
                    tail_last_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            base_q          <= '0;
            num_q           <= '0;
            gamma_q         <= '0;
            issued_q        <= '0;
            accepted_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
            occ_q           <= 2'd0;
            head_q          <= '0;
            tail_q          <= '0;
            head_last_q     <= 1'b0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q     <= base_addr;
                num_q      <= num_vec;
                gamma_q    <= gamma;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (sram_en_int) issued_q <= issued_q + CntW'(1);
                if (pop)         accepted_q <= accepted_q + CntW'(1);
            end
            zero_done_q     <= start_ok && (num_vec == '0);
            inflight_q      <= sram_en_int;
            inflight_last_q <= sram_en_int && issue_last;
            occ_q           <= occ_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            head_last_q     <= head_last_d;
            tail_last_q     <= tail_last_d;
        end
    end

    assign bus.sram_en    = sram_en_int;
    assign bus.sram_addr  = base_q + issued_q[ADDR_W-1:0];
    assign bus.out_valid  = out_valid_int;
    assign bus.out_data   = head_q[127:0];
    assign bus.out_vscale = head_q[135:128];
    assign bus.out_gamma  = gamma_q;
    // Head may hold a stale last entry after the final pop, so qualify with valid.
    assign bus.out_last   = head_last_q && out_valid_int;
    assign busy           = (state_q != StIdle);
    assign done_wire      = zero_done_q || drain_done;

endmodule
